infrared_standard_nec: RTL and testbench
========================================

Name: infrared_standard_nec

Overview:
- NEC infrared remote-control receiver.
- Input is the demodulated, active-low output of an IR receiver head.
- Measures pulse widths with the system clock, decodes the leader, 32 data bits and repeat frames, and validates the command against its inverse.
- Presents the 8-bit command with a one-cycle valid strobe to downstream control logic.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz; all timing thresholds are derived from it as CLK_FREQ/1_000_000 cycles per microsecond.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- ir_in  input  1  asynchronous IR receiver output; idle high, low during carrier bursts
- data_out  output  8  last valid command byte
- data_valid  output  1  one-cycle pulse when a new frame has been accepted
- is_repeat  output  1  one-cycle pulse when a repeat frame is decoded

Behaviour:
- Reset values: data_out=8'h00, data_valid=0, is_repeat=0, FSM=IDLE, synchronizer flops=1, counters=0.
- Input conditioning: ir_in passes through a 2-flop synchronizer; a one-cycle edge detector produces fall/rise strobes.
- Width counter: reset to 0 on every edge and saturates at the 10 ms threshold. Width is 1+ceil(log2(CLK_FREQ/100)) bits (20 bits at 50 MHz).
- Accept windows (in µs):
  - leader low: 8000–10000
  - leader high, data frame: 4000–5000
  - leader high, repeat frame: 2000–2500
  - bit low: 400–700
  - bit high '0': 400–800
  - bit high '1': 1400–1900
- States:
  - IDLE -> LEAD_LOW on fall.
  - LEAD_LOW -> LEAD_HIGH on rise with width in window; otherwise -> IDLE.
  - LEAD_HIGH -> BIT_LOW on fall if width is in the data window, with bit index cleared. -> REP_TAIL if width is in the repeat window. Otherwise -> IDLE.
  - BIT_LOW -> BIT_HIGH on rise with width in window; otherwise -> IDLE.
  - BIT_HIGH, on fall: classify the high width as 0 or 1 and shift it into a 32-bit register, LSB first. Field order: address, ~address, command, ~command. If this was bit 31 -> CHECK; otherwise -> BIT_LOW. An unclassifiable width -> IDLE.
  - CHECK, one cycle: if command == ~command_inv, load data_out=command and pulse data_valid. In either case -> IDLE.
  - REP_TAIL -> IDLE on rise after a 400–700 µs low, pulsing is_repeat. data_out is unchanged.
- Timeout: if the counter reaches the upper bound of the current state's window with no edge, return to IDLE with no output.
- Latency: data_valid rises exactly 4 clk cycles after the ir_in falling edge that starts the stop burst (2 sync + 1 edge + 1 CHECK).
- The stop burst's trailing rise is ignored in IDLE.
- data_valid and is_repeat are never high in the same cycle. Each pulse lasts exactly one cycle.
- A failed check or a timeout leaves data_out at its previous value.
- An asserted rst mid-frame immediately forces reset values; decoding restarts at the next leader.

Optional Feature:
- Macro: NEC_ADDR_CHECK_EN.
- Defined: CHECK additionally requires address == ~address_inv; frames failing this check are dropped without a pulse.
- Undefined: the address bytes are ignored, so extended-NEC 16-bit addresses are accepted.

Decomposition:
- Package infrared_nec_pkg holds:
  - the FSM state enum (IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH, CHECK, REP_TAIL)
  - the µs window constants
  - a function converting µs to cycles given CLK_FREQ
- Sub-module ir_edge_sync: the 2-flop synchronizer and edge detector, with outputs ir_sync, fall and rise.

Test Plan:
- Data frame with address 8'h00, ~address 8'hFF, command 8'h54 (sent LSB first 0,0,1,0,1,0,1,0), ~command 8'hAB, then a 560 µs stop burst -> one data_valid pulse, data_out=8'h54, is_repeat stays 0.
- Same frame but ~command 8'hAC -> no data_valid; data_out keeps its previous value.
- 9 ms low, 2.25 ms high, 560 µs low following a valid frame -> one is_repeat pulse; data_out still 8'h54.
- Leader low of only 5 ms followed by a full frame body -> no data_valid; the FSM returns to IDLE.
- rst asserted after bit 10 of a frame, then a complete valid frame with command 8'h12 -> outputs at reset values during reset, then data_valid with data_out=8'h12.
- With NEC_ADDR_CHECK_EN defined, a frame with address 8'h00 and ~address 8'h00 -> no data_valid. Without the macro, the same frame -> data_valid.

Source files
------------

// File: rtl/infrared_nec_pkg.sv
// Shared definitions for the NEC IR receiver: FSM states, pulse-width accept
// windows in microseconds, and the microsecond-to-clock-cycle conversion.
package infrared_nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LOW,
    LEAD_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK,
    REP_TAIL
  } nec_state_e;

  localparam int LEAD_LOW_MIN_US   = 8000;
  localparam int LEAD_LOW_MAX_US   = 10000;
  localparam int LEAD_DATA_MIN_US  = 4000;
  localparam int LEAD_DATA_MAX_US  = 5000;
  localparam int LEAD_REP_MIN_US   = 2000;
  localparam int LEAD_REP_MAX_US   = 2500;
  localparam int BIT_LOW_MIN_US    = 400;
  localparam int BIT_LOW_MAX_US    = 700;
  localparam int BIT0_HIGH_MIN_US  = 400;
  localparam int BIT0_HIGH_MAX_US  = 800;
  localparam int BIT1_HIGH_MIN_US  = 1400;
  localparam int BIT1_HIGH_MAX_US  = 1900;
  localparam int TIMEOUT_US        = 10000;

  // 64-bit intermediate so large clock frequencies do not overflow.
  function automatic int us_to_cycles(input int us, input int clk_freq);
    longint prod;
    prod = longint'(us) * longint'(clk_freq);
    return int'(prod / longint'(1_000_000));
  endfunction

endpackage

// File: rtl/ir_edge_sync.sv
// Two-flop synchronizer for the asynchronous IR input plus a one-cycle
// fall/rise detector on the synchronized level. Flops reset to the idle-high level.
module ir_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic ir_in,
  output logic ir_sync,
  output logic fall,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= ir_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign ir_sync = sync_q;
  assign fall    = prev_q & ~sync_q;
  assign rise    = ~prev_q & sync_q;

endmodule

// File: rtl/infrared_standard_nec.sv
// NEC IR receiver: measures pulse widths, decodes leader/32-bit/repeat frames.
// Build option NEC_ADDR_CHECK_EN additionally requires address == ~address_inv.
module infrared_standard_nec
  import infrared_nec_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       is_repeat
);

  localparam int CW = 1 + $clog2(CLK_FREQ / 100);
  typedef logic [CW-1:0] cnt_t;

  function automatic cnt_t cyc(input int us);
    return cnt_t'(us_to_cycles(us, CLK_FREQ));
  endfunction

  function automatic logic in_win(input cnt_t w, input cnt_t lo, input cnt_t hi);
    return (w >= lo) && (w <= hi);
  endfunction

  localparam cnt_t LL_MIN  = cyc(LEAD_LOW_MIN_US);
  localparam cnt_t LL_MAX  = cyc(LEAD_LOW_MAX_US);
  localparam cnt_t LD_MIN  = cyc(LEAD_DATA_MIN_US);
  localparam cnt_t LD_MAX  = cyc(LEAD_DATA_MAX_US);
  localparam cnt_t LR_MIN  = cyc(LEAD_REP_MIN_US);
  localparam cnt_t LR_MAX  = cyc(LEAD_REP_MAX_US);
  localparam cnt_t BL_MIN  = cyc(BIT_LOW_MIN_US);
  localparam cnt_t BL_MAX  = cyc(BIT_LOW_MAX_US);
  localparam cnt_t B0_MIN  = cyc(BIT0_HIGH_MIN_US);
  localparam cnt_t B0_MAX  = cyc(BIT0_HIGH_MAX_US);
  localparam cnt_t B1_MIN  = cyc(BIT1_HIGH_MIN_US);
  localparam cnt_t B1_MAX  = cyc(BIT1_HIGH_MAX_US);
  localparam cnt_t TMO     = cyc(TIMEOUT_US);

  nec_state_e  state;
  nec_state_e  state_next;
  logic        ir_sync, fall, rise, ir_edge, rise_evt;
  cnt_t        cnt;
  cnt_t        limit;
  logic        timeout;
  logic [4:0]  bit_idx;
  logic [31:0] shreg;
  logic        is_zero, is_one;
  logic        cmd_ok, addr_ok;
  logic        dv_set, rep_set;

  ir_edge_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .ir_in   (ir_in),
    .ir_sync (ir_sync),
    .fall    (fall),
    .rise    (rise)
  );

  assign ir_edge  = fall | rise;
  assign rise_evt = ir_edge & ir_sync;

  // Width of the level that just ended; restarts on every edge, sticks at 10 ms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (ir_edge)     cnt <= '0;
    else if (cnt != TMO)  cnt <= cnt + cnt_t'(1);
  end

  always_comb begin
    limit = TMO;
    case (state)
      LEAD_LOW:          limit = LL_MAX;
      LEAD_HIGH:         limit = LD_MAX;
      BIT_LOW, REP_TAIL: limit = BL_MAX;
      BIT_HIGH:          limit = B1_MAX;
      default:           limit = TMO;
    endcase
  end

  assign timeout = (state != IDLE) && (state != CHECK) && !ir_edge && (cnt >= limit);
  assign is_zero = in_win(cnt, B0_MIN, B0_MAX);
  assign is_one  = in_win(cnt, B1_MIN, B1_MAX);
  assign cmd_ok  = (shreg[23:16] == ~shreg[31:24]);
`ifdef NEC_ADDR_CHECK_EN
  assign addr_ok = (shreg[7:0] == ~shreg[15:8]);
`else
  assign addr_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (fall) state_next = LEAD_LOW;
      LEAD_LOW:  if (rise_evt) state_next = in_win(cnt, LL_MIN, LL_MAX) ? LEAD_HIGH : IDLE;
      LEAD_HIGH: if (fall) begin
                   if (in_win(cnt, LD_MIN, LD_MAX))      state_next = BIT_LOW;
                   else if (in_win(cnt, LR_MIN, LR_MAX)) state_next = REP_TAIL;
                   else                                  state_next = IDLE;
                 end
      BIT_LOW:   if (rise_evt) state_next = in_win(cnt, BL_MIN, BL_MAX) ? BIT_HIGH : IDLE;
      BIT_HIGH:  if (fall) begin
                   if (!(is_zero || is_one)) state_next = IDLE;
                   else if (bit_idx == 5'd31) state_next = CHECK;
                   else                       state_next = BIT_LOW;
                 end
      CHECK:     state_next = IDLE;
      REP_TAIL:  if (rise_evt) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (timeout) state_next = IDLE;
  end

  // data_valid / is_repeat are single-cycle strobes with no ready; data_out is
  // stable from a data_valid cycle until the next accepted data frame.
  always_comb begin
    dv_set  = (state == CHECK) && cmd_ok && addr_ok;
    rep_set = (state == REP_TAIL) && rise_evt && in_win(cnt, BL_MIN, BL_MAX);
  end

  // Bits arrive LSB first: after 32 shifts shreg = {~cmd, cmd, ~addr, addr}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else if (fall && state == LEAD_HIGH) begin
      bit_idx <= '0;
    end else if (fall && state == BIT_HIGH && (is_zero || is_one)) begin
      shreg   <= {is_one, shreg[31:1]};
      bit_idx <= bit_idx + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      is_repeat  <= 1'b0;
    end else begin
      data_valid <= dv_set;
      is_repeat  <= rep_set;
      if (dv_set) data_out <= shreg[23:16];
    end
  end

endmodule

// File: tb/tb_infrared_standard_nec.sv
// Bench for infrared_standard_nec: NEC frames with randomized pulse widths,
// scoreboarded against a frame-level model of accepted commands and repeats.
module tb_infrared_standard_nec;

  localparam int CLK_FREQ = 50_000;
`ifdef NEC_ADDR_CHECK_EN
  localparam bit ADDR_CHK = 1'b1;
`else
  localparam bit ADDR_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ir_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       is_repeat;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         excl_hits = 0;
  logic [7:0] last_cmd = 8'h00;

  // Event word: {type[1:0] (1 = data_valid, 2 = is_repeat), data[7:0], cycle[21:0]}
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  infrared_standard_nec #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .ir_in      (ir_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .is_repeat  (is_repeat)
  );

  // clock / cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every strobe cycle becomes one observed event
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) obs_q.push_back({2'd1, data_out, cyc[21:0]});
      if (is_repeat)  obs_q.push_back({2'd2, data_out, cyc[21:0]});
      if (data_valid && is_repeat) excl_hits++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int us2cyc(input int us);
    return int'(longint'(us) * CLK_FREQ / 1_000_000);
  endfunction

  // driver: called at a negedge, holds the level for the given time
  task automatic pulse_us(input logic lvl, input int us);
    ir_in = lvl;
    repeat (us2cyc(us)) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] ai, input logic [7:0] c,
                            input logic [7:0] ci, input int lead_us, input int nbits,
                            output int stop_cyc);
    logic [31:0] word;
    word = {ci, c, ai, a};
    stop_cyc = -1;
    pulse_us(1'b0, lead_us);
    pulse_us(1'b1, $urandom_range(4200, 4800));
    for (int i = 0; i < nbits; i++) begin
      pulse_us(1'b0, $urandom_range(480, 640));
      pulse_us(1'b1, word[i] ? $urandom_range(1520, 1840) : $urandom_range(480, 720));
    end
    if (nbits == 32) begin
      stop_cyc = cyc;
      pulse_us(1'b0, $urandom_range(480, 640));
      ir_in = 1'b1;
    end
  endtask

  // scoreboard
  task automatic compare_frame();
    logic [31:0] e, o;
    int d;
    check("event_count", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check("event_type", {30'd0, o[31:30]}, {30'd0, e[31:30]});
      check("event_data", {24'd0, o[29:22]}, {24'd0, e[29:22]});
      if (e[31:30] == 2'd1) begin
        check("valid_latency", {10'd0, o[21:0]}, {10'd0, e[21:0]});
      end else begin
        d = int'(o[21:0]) - int'(e[21:0]);
        check("repeat_near_rise", {31'd0, (d >= 1 && d <= 6)}, 32'd1);
      end
    end
    exp_q.delete();
    obs_q.delete();
    check("data_out_hold", {24'd0, data_out}, {24'd0, last_cmd});
  endtask

  // reference model: a frame is accepted when its leader is good and the
  // inverse bytes match; data_valid is due 4 cycles after the stop-burst fall
  task automatic run_frame(input logic [7:0] a, input logic [7:0] ai, input logic [7:0] c,
                           input logic [7:0] ci, input bit lead_ok);
    int sc;
    send_frame(a, ai, c, ci, lead_ok ? $urandom_range(8400, 9600) : 5000, 32, sc);
    pulse_us(1'b1, 3000);
    if (lead_ok && ci == ~c && (!ADDR_CHK || ai == ~a)) begin
      exp_q.push_back({2'd1, c, 22'(sc + 4)});
      last_cmd = c;
    end
    compare_frame();
  endtask

  task automatic run_repeat();
    int rc;
    pulse_us(1'b0, $urandom_range(8400, 9600));
    pulse_us(1'b1, $urandom_range(2100, 2400));
    pulse_us(1'b0, $urandom_range(480, 640));
    rc = cyc;
    pulse_us(1'b1, 3000);
    exp_q.push_back({2'd2, last_cmd, 22'(rc)});
    compare_frame();
  endtask

  initial begin
    int sc;
    int kind;
    logic [7:0] a, c, m;

    // reset block
    repeat (3) @(negedge clk);
    check("reset_data_out", {24'd0, data_out}, 32'd0);
    check("reset_valid", {31'd0, data_valid}, 32'd0);
    check("reset_repeat", {31'd0, is_repeat}, 32'd0);
    rst = 1'b0;
    pulse_us(1'b1, 1000);

    run_frame(8'h00, 8'hFF, 8'h54, 8'hAB, 1'b1);
    run_frame(8'h00, 8'hFF, 8'h54, 8'hAC, 1'b1);
    run_repeat();
    run_frame(8'h00, 8'hFF, 8'h33, 8'hCC, 1'b0);

    // reset in the middle of a frame
    send_frame(8'h00, 8'hFF, 8'h12, 8'hED, 9000, 11, sc);
    rst = 1'b1;
    ir_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midreset_data_out", {24'd0, data_out}, 32'd0);
      check("midreset_strobes", {30'd0, data_valid, is_repeat}, 32'd0);
    end
    last_cmd = 8'h00;
    rst = 1'b0;
    pulse_us(1'b1, 400);
    compare_frame();
    run_frame(8'h00, 8'hFF, 8'h12, 8'hED, 1'b1);

    run_frame(8'h00, 8'h00, 8'h5A, 8'hA5, 1'b1);

    // truncated frame left to time out, then a clean frame
    send_frame(8'h21, 8'hDE, 8'h77, 8'h88, 9000, 16, sc);
    pulse_us(1'b1, 3000);
    compare_frame();
    run_frame(8'h21, 8'hDE, 8'h3C, 8'hC3, 1'b1);

    for (int i = 0; i < 8; i++) begin
      kind = int'($urandom_range(0, 4));
      a = 8'($urandom_range(0, 255));
      c = 8'($urandom_range(0, 255));
      m = 8'h01 << $urandom_range(0, 7);
      case (kind)
        0:       run_frame(a, ~a, c, ~c, 1'b1);
        1:       run_frame(a, ~a, c, ~c ^ m, 1'b1);
        2:       run_repeat();
        3:       run_frame(a, ~a, c, ~c, 1'b0);
        default: run_frame(a, ~a ^ m, c, ~c, 1'b1);
      endcase
    end

    check("exclusive_strobes", excl_hits, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
